// File: rtl/digit_entry_pkg.sv
// Shared constants for the digit_entry keypad block: key codes and FSM state encoding.
package digit_entry_pkg;

   // FSM state encoding; plain constants keep older tools and netlists happy.
   typedef logic [1:0] state_t;

   localparam state_t ST_EMPTY = 2'd0;
   localparam state_t ST_ONE   = 2'd1;
   localparam state_t ST_TWO   = 2'd2;
   localparam state_t ST_HOLD  = 2'd3;

   // Non-digit key codes; 0xD-0xF are reserved and rejected.
   localparam logic [3:0] KEY_CLR = 4'hA;
   localparam logic [3:0] KEY_BS  = 4'hB;
   localparam logic [3:0] KEY_ENT = 4'hC;

   localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd2bin.sv
// Two-digit BCD to binary converter (tens*10 + ones), purely combinational.
module bcd2bin (
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   output logic [7:0] value
);

   // Widen before multiplying so 9*10 + 9 = 99 fits without truncation.
   assign value = ({4'd0, tens} * 8'd10) + {4'd0, ones};

endmodule

// File: rtl/digit_entry.sv
// Two-digit keypad entry: collects up to two BCD digits, supports clear, backspace and
// enter, and holds the committed binary value until the consumer takes it.
// Optional build macro DIGIT_ENTRY_ROLL_EN: a digit typed with two digits already present
// shifts the entry left instead of being rejected.
module digit_entry #(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic [1:0] digit_count,
   output logic       out_valid,
   output logic [7:0] out_value,
   input  logic       out_ready,
   output logic       err
);

   import digit_entry_pkg::*;

   // Idle counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t              state, state_d;
   logic [3:0]          tens_d, ones_d;
   logic [1:0]          count_d;
   logic [7:0]          value_d;
   logic                err_d;
   logic [IDLE_W-1:0]   idle, idle_d;
   logic [7:0]          bin;
   logic                accept;

   assign key_ready = (state != ST_HOLD);
   assign out_valid = (state == ST_HOLD);
   assign accept    = key_valid & key_ready;

   bcd2bin u_bcd2bin (
      .tens  (tens),
      .ones  (ones),
      .value (bin)
   );

   // Next-state: key decode while entering, handshake wait in HOLD, idle timeout.
   always_comb begin
      state_d = state;
      tens_d  = tens;
      ones_d  = ones;
      count_d = digit_count;
      value_d = out_value;
      err_d   = 1'b0;
      idle_d  = idle;

      if (state == ST_HOLD) begin
         idle_d = '0;
         if (out_ready) begin
            state_d = ST_EMPTY;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            count_d = 2'd0;
         end
      end else if (accept) begin
         idle_d = '0;
         if (key_code <= DIGIT_MAX) begin
            case (state)
               ST_EMPTY: begin
                  state_d = ST_ONE;
                  tens_d  = 4'd0;
                  ones_d  = key_code;
                  count_d = 2'd1;
               end
               ST_ONE: begin
                  state_d = ST_TWO;
                  tens_d  = ones;
                  ones_d  = key_code;
                  count_d = 2'd2;
               end
               default: begin
`ifdef DIGIT_ENTRY_ROLL_EN
                  tens_d = ones;
                  ones_d = key_code;
`else
                  err_d  = 1'b1;
`endif
               end
            endcase
         end else if (key_code == KEY_CLR) begin
            state_d = ST_EMPTY;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            count_d = 2'd0;
         end else if (key_code == KEY_BS) begin
            case (state)
               ST_TWO: begin
                  state_d = ST_ONE;
                  ones_d  = tens;
                  tens_d  = 4'd0;
                  count_d = 2'd1;
               end
               ST_ONE: begin
                  state_d = ST_EMPTY;
                  tens_d  = 4'd0;
                  ones_d  = 4'd0;
                  count_d = 2'd0;
               end
               default: err_d = 1'b1;
            endcase
         end else if (key_code == KEY_ENT) begin
            if (state == ST_EMPTY) begin
               err_d = 1'b1;
            end else begin
               value_d = bin;
               state_d = ST_HOLD;
            end
         end else begin
            err_d = 1'b1;
         end
      end else if (state != ST_EMPTY && TIMEOUT_CYCLES != 0) begin
         // Partial entry left untouched too long is silently discarded.
         if (idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_EMPTY;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            count_d = 2'd0;
            idle_d  = '0;
         end else begin
            idle_d = idle + 1'b1;
         end
      end
   end

   // State and output registers; reset takes effect immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_EMPTY;
         tens        <= 4'd0;
         ones        <= 4'd0;
         digit_count <= 2'd0;
         out_value   <= 8'd0;
         err         <= 1'b0;
         idle        <= '0;
      end else begin
         state       <= state_d;
         tens        <= tens_d;
         ones        <= ones_d;
         digit_count <= count_d;
         out_value   <= value_d;
         err         <= err_d;
         idle        <= idle_d;
      end
   end

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry: directed scenarios plus randomized key traffic,
// all compared against a digit-queue reference model.
module tb_digit_entry;

   localparam int unsigned TMO = 8;
`ifdef DIGIT_ENTRY_ROLL_EN
   localparam bit ROLL_EN = 1'b1;
`else
   localparam bit ROLL_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [1:0] digit_count;
   logic       out_valid;
   logic [7:0] out_value;
   logic       out_ready;
   logic       err;

   int total = 0;
   int bad   = 0;

   // Reference model: the entry is simply the list of digits typed, oldest first.
   int         q[$];
   bit         m_hold;
   logic [7:0] m_oval;
   bit         m_err;
   int         m_idle;

   digit_entry #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ready   (key_ready),
      .tens        (tens),
      .ones        (ones),
      .digit_count (digit_count),
      .out_valid   (out_valid),
      .out_value   (out_value),
      .out_ready   (out_ready),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int entry_value();
      int v = 0;
      foreach (q[i]) v = v * 10 + q[i];
      return v;
   endfunction

   task automatic model_reset();
      q.delete();
      m_hold = 1'b0;
      m_oval = 8'd0;
      m_err  = 1'b0;
      m_idle = 0;
   endtask

   // Apply one clock edge's worth of behaviour using the currently driven inputs.
   task automatic model_edge();
      int kc;
      kc    = int'(key_code);
      m_err = 1'b0;
      if (rst) begin
         model_reset();
      end else if (m_hold) begin
         if (out_ready) begin
            m_hold = 1'b0;
            q.delete();
         end
      end else if (key_valid) begin
         m_idle = 0;
         if (kc <= 9) begin
            if (q.size() < 2) q.push_back(kc);
            else if (ROLL_EN) begin
               void'(q.pop_front());
               q.push_back(kc);
            end else m_err = 1'b1;
         end else if (kc == 10) begin
            q.delete();
         end else if (kc == 11) begin
            if (q.size() == 0) m_err = 1'b1;
            else void'(q.pop_back());
         end else if (kc == 12) begin
            if (q.size() == 0) m_err = 1'b1;
            else begin
               m_oval = 8'(entry_value());
               m_hold = 1'b1;
            end
         end else begin
            m_err = 1'b1;
         end
      end else if (q.size() > 0) begin
         m_idle++;
         if (m_idle == int'(TMO)) begin
            q.delete();
            m_idle = 0;
         end
      end
      if (q.size() == 0) m_idle = 0;
   endtask

   task automatic compare_all();
      int et, eo;
      et = (q.size() == 2) ? q[0] : 0;
      eo = (q.size() > 0) ? q[q.size() - 1] : 0;
      check("tens", 8'(tens), 8'(et));
      check("ones", 8'(ones), 8'(eo));
      check("digit_count", 8'(digit_count), 8'(q.size()));
      check("out_valid", 8'(out_valid), 8'(m_hold));
      check("out_value", out_value, m_oval);
      check("err", 8'(err), 8'(m_err));
      check("key_ready", 8'(key_ready), 8'(!m_hold));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input bit kv, input int kc, input bit ordy);
      key_valid = kv;
      key_code  = 4'(kc);
      out_ready = ordy;
      step();
   endtask

   task automatic key(input int kc);
      drive(1'b1, kc, 1'b1);
   endtask

   task automatic idle(input bit ordy);
      drive(1'b0, 0, ordy);
   endtask

   initial begin
      int pkv;
      rst       = 1'b1;
      key_valid = 1'b0;
      key_code  = 4'd0;
      out_ready = 1'b0;
      model_reset();
      step();
      step();
      rst = 1'b0;
      idle(1'b0);
      check("rst_key_ready", 8'(key_ready), 8'd1);
      check("rst_count", 8'(digit_count), 8'd0);

      // 4, 2, enter: value 42 for exactly one cycle, then empty.
      key(4); key(2); key(12);
      check("d42_valid", 8'(out_valid), 8'd1);
      check("d42_value", out_value, 8'h2A);
      idle(1'b1);
      check("d42_valid_drop", 8'(out_valid), 8'd0);
      check("d42_count", 8'(digit_count), 8'd0);

      // 9, 9, 5: roll or reject depending on build.
      key(9); key(9); key(5);
      check("d995_tens", 8'(tens), 8'd9);
      check("d995_ones", 8'(ones), ROLL_EN ? 8'd5 : 8'd9);
      check("d995_err", 8'(err), ROLL_EN ? 8'd0 : 8'd1);
      key(10);
      check("clr_err", 8'(err), 8'd0);

      // 7, 3, backspace, enter -> 7; then backspace on empty entry is an error.
      key(7); key(3); key(11);
      check("bs_ones", 8'(ones), 8'd7);
      key(12);
      check("d7_value", out_value, 8'd7);
      idle(1'b1);
      key(11);
      check("bs_empty_err", 8'(err), 8'd1);
      idle(1'b0);
      check("err_pulse_end", 8'(err), 8'd0);

      // Enter with consumer stalled while key 1 is pressed.
      key(4); key(2);
      drive(1'b1, 12, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1, 1'b0);
         check("stall_key_ready", 8'(key_ready), 8'd0);
         check("stall_value", out_value, 8'd42);
      end
      idle(1'b1);
      check("stall_not_taken", 8'(digit_count), 8'd0);

      // Idle timeout after one digit.
      key(5);
      for (int i = 0; i < int'(TMO); i++) idle(1'b0);
      check("tmo_count", 8'(digit_count), 8'd0);
      check("tmo_err", 8'(err), 8'd0);

      // Asynchronous reset between edges while two digits are held.
      key(3); key(8);
      check("pre_rst_count", 8'(digit_count), 8'd2);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("arst_tens", 8'(tens), 8'd0);
      check("arst_ones", 8'(ones), 8'd0);
      check("arst_count", 8'(digit_count), 8'd0);
      check("arst_valid", 8'(out_valid), 8'd0);
      check("arst_value", out_value, 8'd0);
      check("arst_err", 8'(err), 8'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(1'b0);

      // Random traffic with varying key density so timeouts also occur.
      pkv = 60;
      for (int n = 0; n < 4000; n++) begin
         int r, kc;
         if (n % 50 == 0) begin
            r   = int'($urandom_range(0, 2));
            pkv = (r == 0) ? 5 : ((r == 1) ? 60 : 95);
         end
         r  = int'($urandom_range(0, 99));
         kc = (r < 65) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 15));
         rst = ($urandom_range(0, 499) == 0);
         drive($urandom_range(0, 99) < pkv, kc, $urandom_range(0, 1) == 1);
         rst = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
